// File: rtl/starfield_gen.sv
// rtl/starfield_gen.sv - LFSR-driven scrolling starfield: per-pixel star test, twinkle luminance, per-frame reseed
module starfield_gen #(
    parameter int            LEN   = 17,
    parameter logic [LEN-1:0] SEED = 17'h1FFFF,
    parameter logic [LEN-1:0] SPEED = 17'd1,
    parameter int            DENS  = 8,
    parameter int            TW    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce_pix,
    input  logic           hblank,
    input  logic           vblank,
    input  logic           freeze,
    input  logic [LEN-1:0] sreg,
    output logic           lfsr_en,
    output logic           lfsr_rst,
    output logic [LEN-1:0] lfsr_seed,
    output logic           star_on,
    output logic [7:0]     star_lum
);

    typedef enum logic {
        S_RESET = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           vb_q;
    logic           lfsr_rst_q, lfsr_rst_d;
    logic [LEN-1:0] offset_q, offset_d;
    logic [7:0]     fcnt_q, fcnt_d;
    logic           star_on_q, star_on_d;
    logic [7:0]     star_lum_q, star_lum_d;

    logic           act;
    logic           hit;
    logic           frame_evt;
    logic [7:0]     lum_base;
    logic [7:0]     lum;

    assign act       = ce_pix & ~hblank & ~vblank;
    assign hit       = &sreg[LEN-1 -: DENS];
    assign lum_base  = sreg[7:0] | 8'h20;
    assign lum       = (sreg[8] & fcnt_q[TW]) ? (lum_base >> 1) : lum_base;

    // vb_q tracks vblank every clk so a rise between pixel strobes is never missed
    assign frame_evt = vblank & ~vb_q & (state_q == S_RUN);

    always_comb begin
        state_d    = state_q;
        lfsr_rst_d = 1'b0;
        offset_d   = offset_q;
        fcnt_d     = fcnt_q;
        star_on_d  = star_on_q;
        star_lum_d = star_lum_q;
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN: begin
                lfsr_rst_d = frame_evt;
                if (frame_evt && !freeze) begin
                    offset_d = offset_q + SPEED;
                    fcnt_d   = fcnt_q + 8'd1;
                end
            end
            default: state_d = S_RESET;
        endcase
        if (ce_pix) begin
            star_on_d  = act & hit;
            star_lum_d = (act & hit) ? lum : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RESET;
            vb_q       <= 1'b1;
            lfsr_rst_q <= 1'b1;
            offset_q   <= SEED;
            fcnt_q     <= 8'h00;
            star_on_q  <= 1'b0;
            star_lum_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            vb_q       <= vblank;
            lfsr_rst_q <= lfsr_rst_d;
            offset_q   <= offset_d;
            fcnt_q     <= fcnt_d;
            star_on_q  <= star_on_d;
            star_lum_q <= star_lum_d;
        end
    end

    // A zero seed would lock the LFSR, so a wrapped offset falls back to SEED
    assign lfsr_seed = (offset_q == '0) ? SEED : offset_q;
    assign lfsr_rst  = lfsr_rst_q;
    assign lfsr_en   = act & ~lfsr_rst_q;
    assign star_on   = star_on_q;
    assign star_lum  = star_lum_q;

endmodule

// File: tb/tb_starfield_gen.sv
// tb/tb_starfield_gen.sv - scoreboard bench for starfield_gen
module tb_starfield_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_pix = 1'b0;
    logic        hblank = 1'b1;
    logic        vblank = 1'b1;
    logic        freeze = 1'b0;
    logic [16:0] sreg = '0;
    logic        lfsr_en;
    logic        lfsr_rst;
    logic [16:0] lfsr_seed;
    logic        star_on;
    logic [7:0]  star_lum;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int rl_cnt = 0;
    int m_rl   = 0;

    logic [16:0] m_off = 17'h1FFFF;
    logic [7:0]  m_fc  = 8'h00;

    logic [8:0]  pix_q[$];
    logic [16:0] seed_q[$];

    starfield_gen dut (
        .clk(clk), .rst(rst), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
        .freeze(freeze), .sreg(sreg), .lfsr_en(lfsr_en), .lfsr_rst(lfsr_rst),
        .lfsr_seed(lfsr_seed), .star_on(star_on), .star_lum(star_lum)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [16:0] sr, input logic a);
        logic [7:0] l;
        l = sr[7:0] | 8'h20;
        if (sr[8] && m_fc[4]) l = l >> 1;
        if (a && (&sr[16:9])) return {1'b1, l};
        return 9'h000;
    endfunction

    always @(posedge clk) begin
        if (!rst && lfsr_en) en_cnt++;
    end

    always @(posedge clk) begin
        if (ce_pix && !rst) begin
            @(negedge clk);
            if (pix_q.size() == 0) begin
                chk("pix_queue_empty", 1, 0);
            end else begin
                logic [8:0] e;
                e = pix_q.pop_front();
                chk("star_on", int'(star_on), int'(e[8]));
                chk("star_lum", int'(star_lum), int'(e[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && lfsr_rst) begin
            rl_cnt++;
            if (seed_q.size() == 0) begin
                chk("reload_unexpected", 1, 0);
            end else begin
                chk("lfsr_seed", int'(lfsr_seed), int'(seed_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_pix(input logic [16:0] sr);
        ce_pix = 1'b1;
        sreg   = sr;
        @(negedge clk);
        ce_pix = 1'b0;
        @(negedge clk);
    endtask

    task automatic pix_m(input logic [16:0] sr);
        pix_q.push_back(model(sr, ~hblank & ~vblank));
        drive_pix(sr);
    endtask

    task automatic pix_x(input logic [16:0] sr, input logic on, input logic [7:0] lum);
        pix_q.push_back({on, lum});
        drive_pix(sr);
    endtask

    task automatic rise();
        vblank = 1'b1;
        if (!freeze) begin
            m_off = m_off + 17'd1;
            m_fc  = m_fc + 8'd1;
        end
        seed_q.push_back((m_off == 17'd0) ? 17'h1FFFF : m_off);
        m_rl++;
        tick(3);
    endtask

    task automatic frame();
        vblank = 1'b0;
        tick(2);
        en_cnt = 0;
        for (int ln = 0; ln < 4; ln++) begin
            hblank = 1'b0;
            for (int p = 0; p < 8; p++) begin
                logic [16:0] r;
                r = 17'($urandom);
                if (p % 3 == 0) r[16:9] = 8'hFF;
                pix_m(r);
            end
            hblank = 1'b1;
            pix_m(17'h1FFFF);
            tick(1);
        end
        chk("lfsr_en_per_frame", en_cnt, 32);
        rise();
    endtask

    initial begin
        seed_q.push_back(17'h1FFFF);
        m_rl = 1;
        tick(2);
        chk("rst_star_on", int'(star_on), 0);
        chk("rst_star_lum", int'(star_lum), 0);
        chk("rst_lfsr_en", int'(lfsr_en), 0);
        chk("rst_seed", int'(lfsr_seed), 'h1FFFF);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tick(3);

        frame();
        frame();
        frame();
        for (int i = 0; i < 12; i++) begin
            vblank = 1'b0;
            tick(2);
            rise();
        end

        vblank = 1'b0;
        hblank = 1'b0;
        tick(2);
        pix_x(17'h1FF55, 1'b1, 8'h75);
        pix_x(17'h0FFFF, 1'b0, 8'h00);
        hblank = 1'b1;
        pix_x(17'h1FF55, 1'b0, 8'h00);
        hblank = 1'b0;

        freeze = 1'b1;
        rise();
        vblank = 1'b0;
        tick(2);
        rise();
        vblank = 1'b0;
        tick(2);
        pix_x(17'h1FF55, 1'b1, 8'h75);
        freeze = 1'b0;
        rise();
        vblank = 1'b0;
        tick(2);
        pix_x(17'h1FF55, 1'b1, 8'h3A);

        #2 rst = 1'b1;
        #1;
        chk("async_star_on", int'(star_on), 0);
        chk("async_star_lum", int'(star_lum), 0);
        chk("async_seed", int'(lfsr_seed), 'h1FFFF);
        chk("async_lfsr_en", int'(lfsr_en), 0);
        m_off  = 17'h1FFFF;
        m_fc   = 8'h00;
        vblank = 1'b1;
        seed_q.push_back(17'h1FFFF);
        m_rl++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tick(2);
        vblank = 1'b0;
        tick(2);
        pix_x(17'h1FF55, 1'b1, 8'h75);
        tick(3);

        chk("reload_pulses", rl_cnt, m_rl);
        chk("pix_queue_left", pix_q.size(), 0);
        chk("seed_queue_left", seed_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/starfield_gen.md
# starfield_gen

Pixel-rate consumer of the `lfsr` block that turns its pseudo-random sequence into a scrolling starfield for the video path. It drives the LFSR's `en`, `rst` and `seed` inputs and samples its `sreg` output. It advances the LFSR once per visible pixel and reseeds it once per frame with a moving offset, so the star pattern scrolls. Each visible pixel is classified as star or background, and a twinkling 8-bit luminance is produced for the colour mixer.

## Interface
Parameters:
- `LEN`, 17: LFSR width. Must be ≥ 9 and must match the attached LFSR instance.
- `SEED`, 17'h1FFFF: reset value of the scroll offset. Also the fallback seed. Must be non-zero.
- `SPEED`, 1: value added to the offset each frame, modulo 2^LEN.
- `DENS`, 8: number of top `sreg` bits that must all be 1 for a star. Range 1..LEN-9.
- `TW`, 4: index of the frame-counter bit used for twinkle. Range 0..7.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ce_pix`  in  1  pixel clock enable.
- `hblank`  in  1  horizontal blanking.
- `vblank`  in  1  vertical blanking.
- `freeze`  in  1  when 1, the offset and frame counter hold (pattern stops scrolling and twinkling).
- `sreg`  in  LEN  LFSR output.
- `lfsr_en`  out  1  LFSR advance enable.
- `lfsr_rst`  out  1  LFSR reload strobe. Synchronous to the LFSR.
- `lfsr_seed`  out  LEN  LFSR reload value.
- `star_on`  out  1  current pixel is a star.
- `star_lum`  out  8  star luminance. 0 when `star_on`=0.

## Operation
- Active pixel: `act = ce_pix & ~hblank & ~vblank`.
- `lfsr_en = act & ~lfsr_rst`. This is combinational, and is 0 while `rst`=1.
- Frame event: the rising edge of `vblank`, detected from a registered copy `vb_q` that is updated every `clk`, not only on `ce_pix`.
- On a frame event with `freeze`=0:
  - `offset <= offset + SPEED`, with an LEN-bit wrap.
  - `fcnt <= fcnt + 1`. `fcnt` is an 8-bit frame counter that wraps 255→0.
- `lfsr_seed = (offset == 0) ? SEED : offset`. This is combinational and never presents 0.
- `lfsr_rst` is registered. It is 1 on the `clk` cycle immediately after the frame event, regardless of `freeze`, and 0 otherwise.
- States: RESET, then RUN. In RUN the block is in one of two phases:
  - VISIBLE: `vblank`=0.
  - RELOAD: the single-cycle `lfsr_rst` pulse.
- Star test, evaluated on `act`: `hit = &sreg[LEN-1 -: DENS]`.
- Luminance on a hit:
  - Base value `lum = sreg[7:0] | 8'h20`, so the minimum visible luminance is 0x20.
  - Twinkle: if `sreg[8] & fcnt[TW]`, then `lum = lum >> 1` (logical shift).
- Output register:
  - On `ce_pix`: `star_on <= act & hit` and `star_lum <= (act & hit) ? lum : 0`.
  - The outputs hold between `ce_pix` strobes.
  - During blanking the outputs clear at the next `ce_pix`.

## Timing
- Reset values: `star_on`=0, `star_lum`=0, `offset`=SEED, `fcnt`=0, `vb_q`=1, `lfsr_rst`=1, `lfsr_en`=0.
- After reset:
  - `lfsr_rst` drops on the first `clk` edge after `rst` deasserts.
  - The LFSR is loaded with SEED during that cycle.
- `vb_q` resets to 1, so a reset released while `vblank`=1 produces no spurious frame event.
- Latency: `star_on`/`star_lum` update on the `clk` edge where `ce_pix`=1, i.e. one `ce_pix` after the `sreg` value that produced them. `sreg` advances on that same edge.
- The reload pulse always falls inside vblank, so it never collides with `lfsr_en`. If the input timing is wrong and `act`=1 while `lfsr_rst`=1, then `lfsr_en` is forced to 0 and reload wins.
- A frame event and `freeze` rising on the same edge: the increment is suppressed and the reload still fires.
- `rst` mid-frame: all state returns to its reset values immediately and asynchronously. The outputs go to 0 in the same cycle.
- Offset wrap to 0: the seed falls back to SEED for that frame. The next increment continues from 0+SPEED.

## Test plan
- Reset release with `vblank`=1: `lfsr_rst`=1 for exactly one `clk` after release, `lfsr_seed`=0x1FFFF, `star_on`=0, `star_lum`=0, and no offset change.
- Three frames with a 4-line × 8-pixel visible area and `ce_pix` every 2nd clk:
  - `lfsr_en` pulses exactly 32 times per frame.
  - The offset steps 0x1FFFF→0x00000→0x00001.
  - The seed presented at the two reloads is 0x1FFFF (fallback), then 0x00001.
- Force `sreg`=0x1FF55 on an active `ce_pix` with `fcnt[4]`=0: `star_on`=1 and `star_lum`=0x75 one `ce_pix` later. With `sreg[8]`=1 and `fcnt`=16 instead: `star_lum`=0x3A.
- Force `sreg`=0x0FFFF while active, then drive any `sreg` value with `hblank`=1: `star_on`=0 and `star_lum`=0 in both cases.
- Hold `freeze`=1 across 2 vblank rises: the offset and `fcnt` are unchanged, and `lfsr_rst` still pulses once per rise.
- Assert `rst` mid-line while `star_on`=1: the outputs clear without waiting for a `clk` edge. `offset` returns to 0x1FFFF and `fcnt` returns to 0.
